// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron front-end blocks: FSM states,
// default widths and a saturating increment usable at any width up to 31 bits.
package neuron_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_WIN_W = 8;
  localparam int DEFAULT_CNT_W = 8;
  localparam int DEFAULT_ISI_W = 8;

  // Callers zero-extend into 32 bits and pass their own ceiling (2^W-1).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_out_reg.sv
// One-deep valid/ready holding register with a sticky overrun flag for results
// that arrive while an unconsumed value is still being held.
module spike_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  input  logic         clear_ovr,
  output logic [W-1:0] data_q,
  output logic         valid,
  output logic         overrun
);

  // Handshake: a value transfers on every rising edge where valid && ready.
  // valid never drops without that transfer, and data_q is frozen while
  // valid && !ready. A load that lands on a transfer edge replaces the value.
  logic can_load;
  logic drop;

  assign can_load = !valid || ready;
  assign drop     = load && !can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      valid  <= 1'b0;
    end else if (load && can_load) begin
      data_q <= data;
      valid  <= 1'b1;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

  // A drop coinciding with a clear still leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a single-bit spike train into a per-window spike count (published
// through a one-deep valid/ready register) and the latest inter-spike interval.
module spike_rate_decoder
  import neuron_pkg::*;
#(
  parameter int WIN_W = DEFAULT_WIN_W,
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int ISI_W = DEFAULT_ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ISI_W-1:0] isi_last,
  output logic             isi_valid,
  output logic             overrun,
  input  logic             clear_ovr,
  output logic             fsm_state
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;
  localparam logic [31:0] ISI_MAX = (32'd1 << ISI_W) - 32'd1;

  state_t           state_q, state_d;
  logic             win_end;
  logic             counting;
  logic             aborting;
  logic [WIN_W-1:0] remaining;
  logic [WIN_W-1:0] win_len_eff;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] spk_cnt_inc;
  logic [CNT_W-1:0] result;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_cnt_inc;
  logic             seen_first;

  assign win_len_eff = (window_len == '0) ? WIN_W'(1) : window_len;
  assign spk_cnt_inc = CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX));
  assign isi_cnt_inc = ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX));
  assign result      = spike_in ? spk_cnt_inc : spk_cnt;
  assign counting    = (state_q == COUNT) && enable;
  assign aborting    = (state_q == COUNT) && !enable;
  assign fsm_state   = logic'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (remaining == WIN_W'(1)) begin
          win_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window counters: reload on entry and at every window end, so windows
  // abut with no dead cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      spk_cnt   <= '0;
    end else if (state_q == IDLE) begin
      remaining <= enable ? win_len_eff : '0;
      spk_cnt   <= '0;
    end else if (aborting) begin
      remaining <= '0;
      spk_cnt   <= '0;
    end else if (win_end) begin
      remaining <= win_len_eff;
      spk_cnt   <= '0;
    end else begin
      remaining <= remaining - WIN_W'(1);
      if (spike_in) spk_cnt <= spk_cnt_inc;
    end
  end

  // Interval tracking runs straight across window boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt    <= '0;
      seen_first <= 1'b0;
      isi_last   <= '0;
      isi_valid  <= 1'b0;
    end else if (aborting) begin
      isi_cnt    <= '0;
      seen_first <= 1'b0;
      isi_valid  <= 1'b0;
    end else if (counting) begin
      if (spike_in) begin
        isi_cnt    <= '0;
        seen_first <= 1'b1;
        if (seen_first) begin
          isi_last  <= isi_cnt_inc;
          isi_valid <= 1'b1;
        end
      end else begin
        isi_cnt <= isi_cnt_inc;
      end
    end
  end

  spike_out_reg #(
    .W(CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (win_end),
    .data      (result),
    .ready     (out_ready),
    .clear_ovr (clear_ovr),
    .data_q    (rate_count),
    .valid     (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: each task drives one scenario and
// compares outputs against hand-computed values on the falling clock edge.
module tb_spike_rate_decoder;
  import neuron_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       spike_in;
  logic [7:0] window_len;
  logic [7:0] rate_count;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] isi_last;
  logic       isi_valid;
  logic       overrun;
  logic       clear_ovr;
  logic       fsm_state;

  int tests_run = 0;
  int fails     = 0;

  spike_rate_decoder #(
    .WIN_W(8),
    .CNT_W(8),
    .ISI_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_count (rate_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .isi_last   (isi_last),
    .isi_valid  (isi_valid),
    .overrun    (overrun),
    .clear_ovr  (clear_ovr),
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Drivers: inputs change on the falling edge, outputs are read there too.
  task automatic step(input logic s);
    spike_in = s;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0;
    out_ready = 1'b0; clear_ovr = 1'b0; window_len = 8'd8;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++; if (rate_count !== 8'd0) begin fails++; $display("FAIL rst_rate: got %0d expected 0", rate_count); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0d expected 0", out_valid); end
    tests_run++; if (isi_last !== 8'd0) begin fails++; $display("FAIL rst_isi: got %0d expected 0", isi_last); end
    tests_run++; if (isi_valid !== 1'b0) begin fails++; $display("FAIL rst_isi_valid: got %0d expected 0", isi_valid); end
    tests_run++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_ovr: got %0d expected 0", overrun); end
    tests_run++; if (fsm_state !== logic'(IDLE)) begin fails++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
    window_len = 8'd2; enable = 1'b1;
    step(1'b0);
    tests_run++; if (fsm_state !== logic'(COUNT)) begin fails++; $display("FAIL enter_count: got %0d expected 1", fsm_state); end
    step(1'b1);
    step(1'b1);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd2) begin fails++; $display("FAIL pre_rst_rate: got valid=%0d rate=%0d expected valid=1 rate=2", out_valid, rate_count); end
    tests_run++; if (isi_valid !== 1'b1 || isi_last !== 8'd1) begin fails++; $display("FAIL pre_rst_isi: got valid=%0d isi=%0d expected valid=1 isi=1", isi_valid, isi_last); end
    step(1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || rate_count !== 8'd0) begin fails++; $display("FAIL async_rst_out: got valid=%0d rate=%0d expected 0 0", out_valid, rate_count); end
    tests_run++; if (isi_valid !== 1'b0 || isi_last !== 8'd0) begin fails++; $display("FAIL async_rst_isi: got valid=%0d isi=%0d expected 0 0", isi_valid, isi_last); end
    tests_run++; if (fsm_state !== logic'(IDLE)) begin fails++; $display("FAIL async_rst_state: got %0d expected 0", fsm_state); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b1);
    tests_run++; if (out_valid !== 1'b0 || isi_valid !== 1'b0) begin fails++; $display("FAIL idle_ignore: got valid=%0d isi_valid=%0d expected 0 0", out_valid, isi_valid); end
    tests_run++; if (fsm_state !== logic'(IDLE)) begin fails++; $display("FAIL idle_stay: got %0d expected 0", fsm_state); end
  endtask

  task automatic test_rate;
    logic [7:0] pat;
    do_reset();
    window_len = 8'd8; out_ready = 1'b1; enable = 1'b1;
    step(1'b0);
    pat = 8'b1100_0101;
    for (int i = 0; i < 8; i++) begin
      step(pat[i]);
      if (i < 7) begin
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rate_early_valid: cycle %0d got %0d expected 0", i + 1, out_valid); end
      end
    end
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd4) begin fails++; $display("FAIL rate_w1: got valid=%0d rate=%0d expected valid=1 rate=4", out_valid, rate_count); end
    pat = 8'b0000_0011;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) window_len = 8'd3;
      step(pat[i]);
      if (i == 0) begin
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rate_pulse: got %0d expected 0", out_valid); end
      end
      if (i == 6) begin
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rate_len_change: got %0d expected 0", out_valid); end
      end
    end
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd2) begin fails++; $display("FAIL rate_w2: got valid=%0d rate=%0d expected valid=1 rate=2", out_valid, rate_count); end
    step(1'b1);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rate_w3_start: got %0d expected 0", out_valid); end
    step(1'b1);
    step(1'b1);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd3) begin fails++; $display("FAIL rate_w3: got valid=%0d rate=%0d expected valid=1 rate=3", out_valid, rate_count); end
    enable = 1'b0;
    step(1'b0);
  endtask

  task automatic test_sat_zero;
    logic [4:0] pz;
    do_reset();
    window_len = 8'd255; out_ready = 1'b1; enable = 1'b1;
    step(1'b1);
    for (int i = 0; i < 255; i++) begin
      step(1'b1);
      if (i == 253) begin
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_early: got %0d expected 0", out_valid); end
      end
    end
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd255) begin fails++; $display("FAIL sat_255: got valid=%0d rate=%0d expected valid=1 rate=255", out_valid, rate_count); end
    do_reset();
    window_len = 8'd0; out_ready = 1'b1; enable = 1'b1;
    step(1'b0);
    pz = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      step(pz[i]);
      tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'(pz[i])) begin fails++; $display("FAIL zero_len: cycle %0d got valid=%0d rate=%0d expected valid=1 rate=%0d", i, out_valid, rate_count, pz[i]); end
    end
    enable = 1'b0;
    step(1'b0);
  endtask

  task automatic test_backpressure;
    do_reset();
    window_len = 8'd4; out_ready = 1'b0; enable = 1'b1;
    step(1'b0);
    step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd1 || overrun !== 1'b0) begin fails++; $display("FAIL bp_w1: got valid=%0d rate=%0d ovr=%0d expected 1 1 0", out_valid, rate_count, overrun); end
    step(1'b1); step(1'b1); step(1'b0);
    tests_run++; if (rate_count !== 8'd1) begin fails++; $display("FAIL bp_stable: got %0d expected 1", rate_count); end
    step(1'b0);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd1 || overrun !== 1'b1) begin fails++; $display("FAIL bp_drop: got valid=%0d rate=%0d ovr=%0d expected 1 1 1", out_valid, rate_count, overrun); end
    clear_ovr = 1'b1;
    step(1'b0);
    clear_ovr = 1'b0;
    tests_run++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_clear: got ovr=%0d valid=%0d expected 0 1", overrun, out_valid); end
    step(1'b1); step(1'b1);
    out_ready = 1'b1;
    step(1'b1);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd3 || overrun !== 1'b0) begin fails++; $display("FAIL bp_swap: got valid=%0d rate=%0d ovr=%0d expected 1 3 0", out_valid, rate_count, overrun); end
    step(1'b1);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_consume: got %0d expected 0", out_valid); end
    out_ready = 1'b0;
    step(1'b0); step(1'b0); step(1'b0);
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd1) begin fails++; $display("FAIL bp_w4: got valid=%0d rate=%0d expected 1 1", out_valid, rate_count); end
    step(1'b0); step(1'b0); step(1'b0);
    clear_ovr = 1'b1;
    step(1'b0);
    clear_ovr = 1'b0;
    tests_run++; if (overrun !== 1'b1 || rate_count !== 8'd1) begin fails++; $display("FAIL bp_set_wins: got ovr=%0d rate=%0d expected 1 1", overrun, rate_count); end
    enable = 1'b0;
    step(1'b0);
  endtask

  task automatic test_isi;
    do_reset();
    window_len = 8'd8; out_ready = 1'b1; enable = 1'b1;
    step(1'b0);
    for (int c = 1; c <= 8; c++) begin
      step((c == 2) || (c == 7) || (c == 8));
      if (c == 6) begin
        tests_run++; if (isi_valid !== 1'b0) begin fails++; $display("FAIL isi_early: got %0d expected 0", isi_valid); end
      end
      if (c == 7) begin
        tests_run++; if (isi_valid !== 1'b1 || isi_last !== 8'd5) begin fails++; $display("FAIL isi_5: got valid=%0d isi=%0d expected 1 5", isi_valid, isi_last); end
      end
      if (c == 8) begin
        tests_run++; if (isi_last !== 8'd1) begin fails++; $display("FAIL isi_1: got %0d expected 1", isi_last); end
      end
    end
    repeat (300) step(1'b0);
    step(1'b1);
    tests_run++; if (isi_valid !== 1'b1 || isi_last !== 8'd255) begin fails++; $display("FAIL isi_sat: got valid=%0d isi=%0d expected 1 255", isi_valid, isi_last); end
    enable = 1'b0;
    step(1'b0);
  endtask

  task automatic test_disable;
    do_reset();
    window_len = 8'd8; out_ready = 1'b1; enable = 1'b1;
    step(1'b0);
    step(1'b1); step(1'b1); step(1'b0);
    tests_run++; if (isi_valid !== 1'b1 || isi_last !== 8'd1) begin fails++; $display("FAIL dis_pre_isi: got valid=%0d isi=%0d expected 1 1", isi_valid, isi_last); end
    enable = 1'b0;
    step(1'b1);
    tests_run++; if (fsm_state !== logic'(IDLE) || isi_valid !== 1'b0) begin fails++; $display("FAIL dis_abort: got state=%0d isi_valid=%0d expected 0 0", fsm_state, isi_valid); end
    tests_run++; if (isi_last !== 8'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL dis_retain: got isi=%0d valid=%0d expected 1 0", isi_last, out_valid); end
    repeat (8) step(1'b1);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dis_no_publish: got %0d expected 0", out_valid); end
    enable = 1'b1;
    step(1'b0);
    for (int c = 1; c <= 8; c++) begin
      step(c == 8);
      if (c == 7) begin
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dis_fresh_len: got %0d expected 0", out_valid); end
      end
    end
    tests_run++; if (out_valid !== 1'b1 || rate_count !== 8'd1) begin fails++; $display("FAIL dis_fresh_rate: got valid=%0d rate=%0d expected 1 1", out_valid, rate_count); end
    tests_run++; if (isi_valid !== 1'b0) begin fails++; $display("FAIL dis_seen_first: got %0d expected 0", isi_valid); end
    enable = 1'b0;
    step(1'b0);
  endtask

  initial begin
    test_reset();
    test_rate();
    test_sat_zero();
    test_backpressure();
    test_isi();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side companion to the LIF neuron. Consumes the neuron's single-bit spike output.
- Converts the spike train into two numbers:
  - a spike count per programmable observation window (rate code);
  - the most recent inter-spike interval (ISI, temporal code).
- Window results leave through a one-deep valid/ready output register, for host readout logic or a downstream serializer.

Parameters:
- WIN_W, 8, width of window_len and of the internal window down-counter.
- CNT_W, 8, width of rate_count. Spike count saturates at 2^CNT_W-1.
- ISI_W, 8, width of isi_last. Interval counter saturates at 2^ISI_W-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  run decoder; low = idle and discard the partial window
- spike_in  input  1  spike from neuron, synchronous to clk, sampled every cycle
- window_len  input  WIN_W  window length in cycles, sampled at window start; 0 is treated as 1
- rate_count  output  CNT_W  spike count of the last published window
- out_valid  output  1  rate_count holds an unconsumed result
- out_ready  input  1  consumer accepts rate_count when out_valid && out_ready
- isi_last  output  ISI_W  cycles between the two most recent spikes
- isi_valid  output  1  at least two spikes seen since enable rose
- overrun  output  1  sticky: a window result was dropped
- clear_ovr  input  1  clears overrun

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE;
  - all counters 0;
  - rate_count=0, out_valid=0, isi_last=0, isi_valid=0, overrun=0.
- IDLE: counters held at 0, spike_in ignored. When enable=1, go to COUNT next cycle.
- On COUNT entry (first window) and on each window restart:
  - remaining <= max(window_len,1);
  - spk_cnt <= 0.
- COUNT, every cycle:
  - if spike_in, spk_cnt saturating-increments;
  - remaining decrements.
- Window end: the COUNT cycle where remaining==1.
  - Result = sat(spk_cnt + spike_in); the final cycle's spike is included.
  - Result is published into the output register at that clock edge, so out_valid rises the next cycle (latency 1 after the last window cycle).
  - The new window starts in the immediately following cycle; no dead cycle.
- Output register rules:
  - handshake (out_valid && out_ready) with no publish: out_valid <= 0;
  - publish while out_valid=0: load the result, out_valid <= 1;
  - publish in the same cycle as a handshake: load the new result, out_valid stays 1, no overrun;
  - publish while out_valid=1 && !out_ready: keep the old rate_count, drop the new one, overrun <= 1.
- rate_count is stable while out_valid=1 && !out_ready.
- overrun:
  - cleared by clear_ovr=1;
  - if a drop and clear_ovr happen in the same cycle, set wins.
- ISI:
  - isi_cnt increments each COUNT cycle without a spike, saturating.
  - On a spike: isi_cnt <= 0; if seen_first=1, then isi_last <= sat(isi_cnt+1) and isi_valid <= 1; seen_first <= 1.
  - Example: spikes in consecutive cycles give isi_last=1.
  - ISI tracking is continuous across window boundaries.
- enable falls mid-window:
  - return to IDLE next cycle;
  - partial window discarded, nothing published;
  - spk_cnt, isi_cnt, seen_first and isi_valid cleared;
  - output register, isi_last and overrun retained.
  - A spike in that same cycle is ignored.
- window_len changes mid-window have no effect until the next window start.

Decomposition:
- Shared package (neuron_pkg):
  - state enum {IDLE, COUNT};
  - default widths WIN_W, CNT_W, ISI_W;
  - a saturating-increment function.
- Natural sub-module: spike_out_reg, the one-deep valid/ready holding register with overrun detection. It is reused by future readout blocks.

Test Plan:
- Reset: assert rst_n=0 mid-window without a clock edge → all outputs 0 immediately; after release with enable=0, spikes ignored, out_valid stays 0.
- Rate: window_len=8, spikes on cycles 1,3,7,8 of the window, out_ready=1 → rate_count=4, out_valid pulses for 1 cycle, 1 cycle after window end; the next window counts from 0 with no gap.
- Saturation/zero length, CNT_W=8:
  - window_len=255 with a constant spike → rate_count=255;
  - window_len=0 → window of 1 cycle, rate_count equals the spike_in of each cycle.
- Backpressure:
  - window_len=4, out_ready=0 for 2 windows → first result held, second dropped, overrun=1;
  - clear_ovr pulse → overrun=0;
  - out_ready=1 on the publish cycle → new value loaded, no overrun.
- ISI:
  - spikes at COUNT cycles 2, 7, 8 → isi_valid rises after the cycle-7 spike with isi_last=5, then isi_last=1;
  - 300 silent cycles then a spike → isi_last=255.
- Mid-window disable: enable low after 3 of 8 cycles with 2 spikes → no publish, isi_valid=0; re-enable → fresh 8-cycle window counts from 0.
